// File: rtl/obi_mux_n_to_1.sv
// -----------------------------------------------------------------------------
// obi_mux_n_to_1
//
// N-controller to 1-port OBI arbiter/multiplexer. Several OBI initiators share
// one slave port. Address phases are arbitrated and forwarded with zero
// latency. The winner of every accepted transaction is recorded in a small
// in-order FIFO, and each slave response is routed back to the controller at
// the FIFO head.
//
// Parameters
//   NUM_CTRL         number of controller ports (2..8)
//   MAX_OUTSTANDING  accepted-but-unanswered transactions allowed (1..8)
//
// Ports
//   clk_i, rst_i     clock and synchronous active-high reset
//   ctrl_req_i       per-controller request
//   ctrl_gnt_o       per-controller grant (one-hot or zero)
//   ctrl_addr_i      packed addresses, controller k at [32k+:32]
//   ctrl_we_i        write enables
//   ctrl_be_i        packed byte enables, controller k at [4k+:4]
//   ctrl_wdata_i     packed write data, controller k at [32k+:32]
//   ctrl_rvalid_o    per-controller response valid (one-hot or zero)
//   ctrl_rdata_o     read data broadcast to all controllers
//   port_*           single slave-side OBI port (req/gnt/addr/we/be/wdata,
//                    rvalid/rdata)
//   bad_state_o      one-cycle pulse after a response that arrived while no
//                    transaction was outstanding
//
// Configuration macro
//   OBI_MUX_FIXED_PRIO_EN  defined: fixed priority, lowest requesting index
//                          wins and the round-robin pointer stays at 0.
//                          Undefined (default): round-robin arbitration.
// -----------------------------------------------------------------------------
module obi_mux_n_to_1 #(
  parameter int NUM_CTRL        = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_CTRL-1:0]    ctrl_req_i,
  output logic [NUM_CTRL-1:0]    ctrl_gnt_o,
  input  logic [NUM_CTRL*32-1:0] ctrl_addr_i,
  input  logic [NUM_CTRL-1:0]    ctrl_we_i,
  input  logic [NUM_CTRL*4-1:0]  ctrl_be_i,
  input  logic [NUM_CTRL*32-1:0] ctrl_wdata_i,
  output logic [NUM_CTRL-1:0]    ctrl_rvalid_o,
  output logic [31:0]            ctrl_rdata_o,
  output logic                   port_req_o,
  input  logic                   port_gnt_i,
  output logic [31:0]            port_addr_o,
  output logic                   port_we_o,
  output logic [3:0]             port_be_o,
  output logic [31:0]            port_wdata_o,
  input  logic                   port_rvalid_i,
  input  logic [31:0]            port_rdata_i,
  output logic                   bad_state_o
);

  localparam int IDX_W = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] r_rr_ptr;
  logic             r_locked;
  logic [IDX_W-1:0] r_lock_idx;
  logic [IDX_W-1:0] r_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_bad_state;

  // ---------------------------------------------------------------------------
  // Unpack controller payloads
  // ---------------------------------------------------------------------------
  logic [31:0] w_addr  [NUM_CTRL];
  logic        w_we    [NUM_CTRL];
  logic [3:0]  w_be    [NUM_CTRL];
  logic [31:0] w_wdata [NUM_CTRL];

  for (genvar gi = 0; gi < NUM_CTRL; gi++) begin : g_unpack
    assign w_addr[gi]  = ctrl_addr_i[32*gi +: 32];
    assign w_we[gi]    = ctrl_we_i[gi];
    assign w_be[gi]    = ctrl_be_i[4*gi +: 4];
    assign w_wdata[gi] = ctrl_wdata_i[32*gi +: 32];
  end

  // ---------------------------------------------------------------------------
  // Arbitration: search starts at r_rr_ptr and wraps. In fixed-priority builds
  // the pointer never moves from 0, so the same search yields lowest-index-wins.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] w_arb_sel;
  logic             w_arb_found;
  logic [IDX_W-1:0] w_cand;

  always_comb begin
    w_arb_sel   = '0;
    w_arb_found = 1'b0;
    w_cand      = '0;
    for (int i = 0; i < NUM_CTRL; i++) begin
      w_cand = IDX_W'((int'(r_rr_ptr) + i) % NUM_CTRL);
      if (!w_arb_found && ctrl_req_i[w_cand]) begin
        w_arb_found = 1'b1;
        w_arb_sel   = w_cand;
      end
    end
  end

  // A stalled address phase keeps its owner so the payload stays stable.
  logic [IDX_W-1:0] w_sel;
  assign w_sel = r_locked ? r_lock_idx : w_arb_sel;

  // ---------------------------------------------------------------------------
  // Request / response handshakes
  // ---------------------------------------------------------------------------
  logic             w_full;
  logic             w_empty;
  logic             w_port_req;
  logic             w_accept;
  logic             w_pop;
  logic [IDX_W-1:0] w_head;

  assign w_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_empty = (r_count == '0);

  // Full blocks the request even when a pop happens in the same cycle; this
  // keeps the request path free of any dependency on port_rvalid_i.
  assign w_port_req = !rst_i && ctrl_req_i[w_sel] && !w_full;
  assign w_accept   = w_port_req && port_gnt_i;

  // Only responses for already-recorded transactions are forwarded; a
  // same-cycle grant is never the target of a response.
  assign w_pop  = !rst_i && port_rvalid_i && !w_empty;
  assign w_head = r_fifo[r_rd_ptr];

  for (genvar gi = 0; gi < NUM_CTRL; gi++) begin : g_route
    assign ctrl_gnt_o[gi]    = w_accept && (w_sel == IDX_W'(gi));
    assign ctrl_rvalid_o[gi] = w_pop && (w_head == IDX_W'(gi));
  end

  assign port_req_o   = w_port_req;
  assign port_addr_o  = w_addr[w_sel];
  assign port_we_o    = w_we[w_sel];
  assign port_be_o    = w_be[w_sel];
  assign port_wdata_o = w_wdata[w_sel];
  assign ctrl_rdata_o = port_rdata_i;
  assign bad_state_o  = r_bad_state;

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr    <= '0;
      r_locked    <= 1'b0;
      r_lock_idx  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_bad_state <= 1'b0;
    end else begin
      r_bad_state <= port_rvalid_i && w_empty;

      if (w_accept) begin
        r_locked <= 1'b0;
`ifndef OBI_MUX_FIXED_PRIO_EN
        r_rr_ptr <= (w_sel == IDX_W'(NUM_CTRL - 1)) ? '0 : w_sel + 1'b1;
`endif
      end else if (w_port_req) begin
        r_locked   <= 1'b1;
        r_lock_idx <= w_sel;
      end

      if (w_accept) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_rd_ptr + 1'b1;
      end

      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Winner storage; contents are only meaningful between write and read
  // pointers, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_fifo[r_wr_ptr] <= w_sel;
    end
  end

endmodule
